// File: rtl/spi_frame_scheduler.sv
// Bundles quaternion/gyro samples into coherent frames for the MCU SPI slave, freezing them during cs_n low.
// Optional SPI_SCHED_SEQ_EN adds a 6-bit frame sequence number in frm_flags[7:2].
module spi_frame_scheduler #(
   parameter int DATA_W         = 16,
   parameter int SYNC_STAGES    = 2,
   parameter int COMMIT_TIMEOUT = 4096,
   parameter int HOLDOFF_CYCLES = 8,
   parameter int OVR_W          = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cs_n,
   input  logic                     quat_valid,
   input  logic signed [DATA_W-1:0] quat_w,
   input  logic signed [DATA_W-1:0] quat_x,
   input  logic signed [DATA_W-1:0] quat_y,
   input  logic signed [DATA_W-1:0] quat_z,
   input  logic                     gyro_valid,
   input  logic signed [DATA_W-1:0] gyro_x,
   input  logic signed [DATA_W-1:0] gyro_y,
   input  logic signed [DATA_W-1:0] gyro_z,
   output logic signed [DATA_W-1:0] frm_quat_w,
   output logic signed [DATA_W-1:0] frm_quat_x,
   output logic signed [DATA_W-1:0] frm_quat_y,
   output logic signed [DATA_W-1:0] frm_quat_z,
   output logic signed [DATA_W-1:0] frm_gyro_x,
   output logic signed [DATA_W-1:0] frm_gyro_y,
   output logic signed [DATA_W-1:0] frm_gyro_z,
   output logic [7:0]               frm_flags,
   output logic                     drdy,
   output logic [OVR_W-1:0]         ovr_cnt,
   output logic                     busy
);

   localparam int TMO_W = $clog2(COMMIT_TIMEOUT);
   localparam int HO_W  = $clog2(HOLDOFF_CYCLES) + 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(COMMIT_TIMEOUT - 1);
   localparam logic [HO_W-1:0]  HO_LAST  = HO_W'(HOLDOFF_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, COLLECT, LOCKED, HOLDOFF} state_t;

   state_t                   r_state, w_state_nxt;
   logic [SYNC_STAGES-1:0]   r_cs_sync;
   logic                     r_cs_d;
   logic                     w_cs_s, w_cs_fall, w_cs_rise;
   logic [TMO_W-1:0]         r_tmo, w_tmo_nxt;
   logic [HO_W-1:0]          r_ho, w_ho_nxt;
   logic                     w_commit, w_any_vld;
   logic                     r_fresh_q, r_fresh_g;
   logic [1:0]               r_flags_lo;
   logic signed [DATA_W-1:0] r_sq_w, r_sq_x, r_sq_y, r_sq_z;
   logic signed [DATA_W-1:0] r_sg_x, r_sg_y, r_sg_z;

   // Synchroniser flops reset high so a released reset never looks like a cs_n falling edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cs_sync <= '1;
         r_cs_d    <= 1'b1;
      end else begin
         r_cs_sync <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
         r_cs_d    <= w_cs_s;
      end
   end

   assign w_cs_s    = r_cs_sync[SYNC_STAGES-1];
   assign w_cs_fall = r_cs_d & ~w_cs_s;
   assign w_cs_rise = ~r_cs_d & w_cs_s;
   assign w_any_vld = quat_valid | gyro_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_tmo   <= '0;
         r_ho    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_tmo   <= w_tmo_nxt;
         r_ho    <= w_ho_nxt;
      end
   end

   // A cs_s fall pre-empts everything, including a commit that would otherwise fire this cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_tmo_nxt   = r_tmo;
      w_ho_nxt    = r_ho;
      w_commit    = 1'b0;
      if (w_cs_fall) begin
         w_state_nxt = LOCKED;
         w_ho_nxt    = '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_any_vld) begin
                  w_state_nxt = COLLECT;
                  w_tmo_nxt   = '0;
               end
            end
            COLLECT: begin
               if ((r_fresh_q & r_fresh_g) || (r_tmo >= TMO_LAST)) begin
                  w_commit    = 1'b1;
                  w_tmo_nxt   = '0;
                  w_state_nxt = w_any_vld ? COLLECT : IDLE;
               end else begin
                  w_tmo_nxt = r_tmo + 1'b1;
               end
            end
            LOCKED: begin
               if (w_cs_rise) begin
                  w_state_nxt = HOLDOFF;
                  w_ho_nxt    = '0;
               end
            end
            HOLDOFF: begin
               if (r_ho == HO_LAST) begin
                  w_state_nxt = (r_fresh_q | r_fresh_g | w_any_vld) ? COLLECT : IDLE;
               end else begin
                  w_ho_nxt = r_ho + 1'b1;
               end
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   // Staging runs in every state; a new sample's fresh bit survives a same-cycle commit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sq_w    <= '0;
         r_sq_x    <= '0;
         r_sq_y    <= '0;
         r_sq_z    <= '0;
         r_sg_x    <= '0;
         r_sg_y    <= '0;
         r_sg_z    <= '0;
         r_fresh_q <= 1'b0;
         r_fresh_g <= 1'b0;
      end else begin
         if (quat_valid) begin
            r_sq_w <= quat_w;
            r_sq_x <= quat_x;
            r_sq_y <= quat_y;
            r_sq_z <= quat_z;
         end
         if (gyro_valid) begin
            r_sg_x <= gyro_x;
            r_sg_y <= gyro_y;
            r_sg_z <= gyro_z;
         end
         r_fresh_q <= quat_valid | (r_fresh_q & ~w_commit);
         r_fresh_g <= gyro_valid | (r_fresh_g & ~w_commit);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frm_quat_w <= '0;
         frm_quat_x <= '0;
         frm_quat_y <= '0;
         frm_quat_z <= '0;
         frm_gyro_x <= '0;
         frm_gyro_y <= '0;
         frm_gyro_z <= '0;
         r_flags_lo <= 2'b00;
         drdy       <= 1'b0;
         ovr_cnt    <= '0;
      end else begin
         if (w_commit) begin
            frm_quat_w <= r_sq_w;
            frm_quat_x <= r_sq_x;
            frm_quat_y <= r_sq_y;
            frm_quat_z <= r_sq_z;
            frm_gyro_x <= r_sg_x;
            frm_gyro_y <= r_sg_y;
            frm_gyro_z <= r_sg_z;
            r_flags_lo <= {r_fresh_g, r_fresh_q};
            drdy       <= 1'b1;
            if (drdy && (ovr_cnt != {OVR_W{1'b1}}))
               ovr_cnt <= ovr_cnt + 1'b1;
         end else if (w_cs_fall) begin
            drdy <= 1'b0;
         end
      end
   end

`ifdef SPI_SCHED_SEQ_EN
   logic [5:0] r_seq;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_seq <= 6'd0;
      else if (w_commit)
         r_seq <= r_seq + 6'd1;
   end

   assign frm_flags = {r_seq, r_flags_lo};
`else
   assign frm_flags = {6'b0, r_flags_lo};
`endif

   assign busy = (r_state == LOCKED) || (r_state == HOLDOFF);

endmodule
